// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared FSM state and shift-direction encodings for word_deser
package deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/deser_out_slot.sv
// rtl/deser_out_slot.sv - single-entry output holding slot with accept, replace and sticky overflow
module deser_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_perr_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             perr_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] word_q;
  logic             valid_q;
  logic             perr_q;
  logic             ovf_q;
  logic             slot_free;

  // An accepting consumer frees the slot in the same cycle, allowing a back-to-back replace.
  assign slot_free = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      if (slot_free) begin
        word_q  <= load_data_i;
        valid_q <= 1'b1;
        perr_q  <= load_perr_i;
      end else begin
        ovf_q   <= 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign word_o     = word_q;
  assign valid_o    = valid_q;
  assign perr_o     = perr_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/word_deser.sv
// rtl/word_deser.sv - serial bit to parallel word deserializer; WORD_DESER_PARITY_EN adds an even-parity frame bit
module word_deser
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             dir,
  input  logic             flush,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] coll_q;
  logic             dir_q;

  logic             shift_dir;
  logic [WIDTH-1:0] coll_d;
  logic             done;
  logic [WIDTH-1:0] done_data;
  logic             done_perr;

  always_comb begin
    shift_dir = (state_q == ST_IDLE) ? dir : dir_q;
    coll_d    = (shift_dir == DIR_RIGHT) ? {bit_in, coll_q[WIDTH-1:1]}
                                         : {coll_q[WIDTH-2:0], bit_in};
`ifdef WORD_DESER_PARITY_EN
    done      = bit_valid && !flush && (state_q == ST_PARITY);
    done_data = coll_q;
    done_perr = (^coll_q) ^ bit_in;
`else
    done      = bit_valid && !flush && (state_q == ST_SHIFT) && (cnt_q == LAST);
    done_data = coll_d;
    done_perr = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      coll_q  <= '0;
      dir_q   <= DIR_LEFT;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      coll_q  <= '0;
    end else if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          dir_q   <= dir;
          coll_q  <= coll_d;
          cnt_q   <= CW'(1);
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          coll_q <= coll_d;
          if (cnt_q == LAST) begin
`ifdef WORD_DESER_PARITY_EN
            cnt_q   <= CW'(WIDTH);
            state_q <= ST_PARITY;
`else
            cnt_q   <= '0;
            coll_q  <= '0;
            state_q <= ST_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          coll_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  deser_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk_i       (clk),
    .rst_ni      (reset),
    .load_i      (done),
    .load_data_i (done_data),
    .load_perr_i (done_perr),
    .ready_i     (word_ready),
    .word_o      (word_out),
    .valid_o     (word_valid),
    .perr_o      (parity_err),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_word_deser.sv
// tb/tb_word_deser.sv - directed and randomized checks of word_deser against a bit-queue reference model
module tb_word_deser;

  localparam int W = 4;
`ifdef WORD_DESER_PARITY_EN
  localparam int FRAME = W + 1;
  localparam bit PEN = 1'b1;
`else
  localparam int FRAME = W;
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, dir = 1'b0, flush = 1'b0, word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic word_valid, overflow, parity_err;

  int compared = 0;
  int mismatched = 0;

  logic q[$];
  logic m_dir = 1'b0;
  logic [W-1:0] m_word = '0;
  logic m_valid = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;

  word_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .dir        (dir),
    .flush      (flush),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_out"}, word_out, m_word);
    chk({tag, ".word_valid"}, W'(word_valid), W'(m_valid));
    chk({tag, ".overflow"}, W'(overflow), W'(m_ovf));
    chk({tag, ".parity_err"}, W'(parity_err), W'(m_perr));
  endtask

  task automatic model_reset();
    q.delete();
    m_word = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_perr = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the rules, then compare after the edge.
  task automatic step(input string tag, input logic bv, input logic b, input logic d,
                      input logic fl, input logic rdy);
    logic done;
    logic [W-1:0] w;
    logic par;
    bit_valid = bv; bit_in = b; dir = d; flush = fl; word_ready = rdy;
    done = 1'b0; w = '0; par = 1'b0;
    if (fl) q.delete();
    else if (bv) begin
      if (q.size() == 0) m_dir = d;
      q.push_back(b);
      if (q.size() == FRAME) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          if (m_dir) w[i] = q[i];
          else w[W-1-i] = q[i];
        end
        for (int i = 0; i < FRAME; i++) par = par ^ q[i];
        q.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word = w;
        m_valid = 1'b1;
        m_perr = PEN ? par : 1'b0;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] w, input logic d, input logic rdy_last);
    for (int i = 0; i < W; i++)
      step(tag, 1'b1, d ? w[i] : w[W-1-i], d, 1'b0, (i == W-1 && !PEN) ? rdy_last : 1'b0);
    if (PEN) step(tag, 1'b1, ^w, d, 1'b0, rdy_last);
  endtask

  task automatic pulse_reset(input string tag);
    bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    send_word("r033", 4'hD, 1'b1, 1'b0);
    chk("r033.const", word_out, 4'hD);
    chk("r033.valid", W'(word_valid), W'(1));
    step("r033.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send_word("r034a", 4'hB, 1'b0, 1'b0);
    chk("r034a.const", word_out, 4'hB);
    step("r034a.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("r034b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r034b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("r034b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r034b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (PEN) step("r034b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("r034b.const", word_out, 4'hB);
    chk("r034b.valid", W'(word_valid), W'(1));

    pulse_reset("r035.rst1");
    send_word("r035a", 4'hD, 1'b1, 1'b0);
    send_word("r035a", 4'h3, 1'b1, 1'b0);
    chk("r035a.const", word_out, 4'hD);
    chk("r035a.ovf", W'(overflow), W'(1));
    pulse_reset("r035.rst2");
    send_word("r035b", 4'hD, 1'b1, 1'b0);
    send_word("r035b", 4'h3, 1'b1, 1'b1);
    chk("r035b.const", word_out, 4'h3);
    chk("r035b.ovf", W'(overflow), W'(0));
    chk("r035b.valid", W'(word_valid), W'(1));
    step("r035b.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("r035b.cleared", W'(word_valid), W'(0));

    step("r036", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r036", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r036.flush", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("r036", 4'h3, 1'b0, 1'b0);
    chk("r036.const", word_out, 4'h3);
    step("r036.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("r036b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r036b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r036b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reset("r036b.rst");
    chk("r036b.zero", word_out, 4'h0);
    send_word("r036b", 4'h6, 1'b1, 1'b0);
    chk("r036b.const", word_out, 4'h6);
    step("r036b.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef WORD_DESER_PARITY_EN
    step("r037a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r037a", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("r037a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r037a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("r037a.not_yet", W'(word_valid), W'(0));
    step("r037a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("r037a.valid", W'(word_valid), W'(1));
    chk("r037a.perr", W'(parity_err), W'(0));
    chk("r037a.const", word_out, 4'hD);
    step("r037a.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("r037b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r037b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("r037b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r037b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r037b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("r037b.perr", W'(parity_err), W'(1));
    step("r037b.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      if (n == 200) pulse_reset("rand.rst");
      step("rand", $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
